q_greedy_stepper: RTL and testbench



---
 rtl/q_maze_pkg.sv | 34 +++
 rtl/q_move_legal.sv | 57 +++++
 rtl/q_greedy_stepper.sv | 157 +++++++++++++++
 tb/tb_q_greedy_stepper.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/q_maze_pkg.sv
// Shared types for the Q-learning maze datapath.
// Actions, walker FSM states and per-action cell offsets.
package q_maze_pkg;

  typedef enum logic [1:0] {
    A_DOWN  = 2'd0,
    A_RIGHT = 2'd1,
    A_UP    = 2'd2,
    A_LEFT  = 2'd3
  } action_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_MOVE,
    S_CHECK,
    S_DONE
  } walk_state_t;

  localparam int N_ACT     = 4;
  localparam int OFS_RIGHT = 1;
  localparam int OFS_LEFT  = -1;

  // Signed cell-index offset of an action; vertical moves scale with COLS.
  function automatic int act_step(input action_t a, input int cols);
    unique case (a)
      A_DOWN:  act_step = cols;
      A_RIGHT: act_step = OFS_RIGHT;
      A_UP:    act_step = -cols;
      default: act_step = OFS_LEFT;
    endcase
  endfunction

endpackage

// File: rtl/q_move_legal.sv
// Combinational legality and destination of the four moves from a cell.
// Bounds are checked before any subtraction so nothing wraps.
module q_move_legal
  import q_maze_pkg::*;
#(
  parameter int ROWS      = 6,
  parameter int COLS      = 6,
  parameter int N_BLOCKED = 16,
  parameter int STATE_W   = $clog2(ROWS*COLS+1)
) (
  input  logic [STATE_W-1:0] cur_state,
  input  logic [STATE_W-1:0] blocked [N_BLOCKED],
  output logic [3:0]         legal,
  output logic [STATE_W-1:0] dest [N_ACT]
);

  localparam int N_CELLS = ROWS * COLS;

  logic [STATE_W:0]   s_ext;
  logic [STATE_W-1:0] col;
  logic [3:0]         in_grid;
  logic [3:0]         hit;

  assign s_ext = {1'b0, cur_state};
  assign col   = cur_state % STATE_W'(COLS);

  always_comb begin
    in_grid = '0;
    in_grid[A_DOWN]  = (cur_state != '0) &&
      ((s_ext + (STATE_W+1)'(COLS)) <= (STATE_W+1)'(N_CELLS));
    in_grid[A_RIGHT] = (cur_state != '0) &&
      (s_ext < (STATE_W+1)'(N_CELLS)) && (col != '0);
    in_grid[A_UP]    = s_ext > (STATE_W+1)'(COLS);
    in_grid[A_LEFT]  = (COLS > 1) && (s_ext > (STATE_W+1)'(1)) &&
      (col != STATE_W'(1));
  end

  always_comb begin
    for (int a = 0; a < N_ACT; a++) begin
      dest[a] = STATE_W'(int'(cur_state) + act_step(action_t'(a), COLS));
    end
  end

  // A destination is blocked if any occupied slot names it.
  always_comb begin
    hit = '0;
    for (int a = 0; a < N_ACT; a++) begin
      for (int i = 0; i < N_BLOCKED; i++) begin
        if (blocked[i] != '0 && blocked[i] == dest[a])
          hit[a] = 1'b1;
      end
    end
  end

  assign legal = in_grid & ~hit;

endmodule

// File: rtl/q_greedy_stepper.sv
// Greedy exploit walker: repeatedly takes the best legal Q action
// from the current cell until target, dead end or step budget.
module q_greedy_stepper
  import q_maze_pkg::*;
#(
  parameter int ROWS      = 6,
  parameter int COLS      = 6,
  parameter int N_BLOCKED = 16,
  parameter int Q_W       = 32,
  parameter int MAX_STEPS = 64,
  localparam int N_CELLS  = ROWS * COLS,
  localparam int STATE_W  = $clog2(N_CELLS + 1),
  localparam int STEP_W   = $clog2(MAX_STEPS + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [STATE_W-1:0] start_state,
  input  logic [STATE_W-1:0] target_state,
  input  logic [STATE_W-1:0] blocked [N_BLOCKED],
  output logic               q_rd_en,
  output logic [STATE_W-1:0] q_rd_state,
  output logic [1:0]         q_rd_action,
  input  logic [Q_W-1:0]     q_rd_data,
  output logic               move_valid,
  output logic [STATE_W-1:0] move_state,
  input  logic               move_ready,
  output logic [STATE_W-1:0] cur_state,
  output logic [STEP_W-1:0]  step_count,
  output logic               busy,
  output logic               done,
  output logic               target_reached,
  output logic               stuck,
  output logic               timeout
);

  walk_state_t st, st_nxt;

  logic [2:0]         fc;
  logic [STATE_W-1:0] tgt;
  logic [3:0]         legal;
  logic [STATE_W-1:0] dest [N_ACT];

  logic signed [Q_W-1:0] best_q, cand_q;
  action_t               best_a, cand_a, rd_a;
  logic                  best_v, cand_v, take;
  logic                  fetch_last, hit_tgt, hit_max;

  q_move_legal #(
    .ROWS      (ROWS),
    .COLS      (COLS),
    .N_BLOCKED (N_BLOCKED),
    .STATE_W   (STATE_W)
  ) u_legal (
    .cur_state (cur_state),
    .blocked   (blocked),
    .legal     (legal),
    .dest      (dest)
  );

  assign fetch_last = (fc == 3'd4);
  assign hit_tgt    = (cur_state == tgt);
  assign hit_max    = (step_count == STEP_W'(MAX_STEPS));

  // Data captured in fetch cycle k belongs to the action read in k-1.
  always_comb begin
    rd_a   = action_t'(fc[1:0] - 2'd1);
    take   = (st == S_FETCH) && (fc != 3'd0) && legal[rd_a] &&
             (!best_v || ($signed(q_rd_data) > best_q));
    cand_v = best_v | take;
    cand_q = take ? $signed(q_rd_data) : best_q;
    cand_a = take ? rd_a : best_a;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= S_IDLE;
    else     st <= st_nxt;
  end

  always_comb begin
    st_nxt = st;
    unique case (st)
      S_IDLE, S_DONE: if (start) st_nxt = S_CHECK;
      S_CHECK: begin
        if (hit_tgt || hit_max) st_nxt = S_DONE;
        else                    st_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (fetch_last) st_nxt = cand_v ? S_MOVE : S_DONE;
      end
      S_MOVE:  if (move_ready) st_nxt = S_CHECK;
      default: st_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state      <= '0;
      tgt            <= '0;
      step_count     <= '0;
      move_state     <= '0;
      fc             <= '0;
      best_q         <= '0;
      best_a         <= A_DOWN;
      best_v         <= 1'b0;
      target_reached <= 1'b0;
      stuck          <= 1'b0;
      timeout        <= 1'b0;
    end else begin
      unique case (st)
        S_IDLE, S_DONE: begin
          if (start) begin
            cur_state      <= start_state;
            tgt            <= target_state;
            step_count     <= '0;
            target_reached <= 1'b0;
            stuck          <= 1'b0;
            timeout        <= 1'b0;
          end
        end
        S_CHECK: begin
          fc     <= '0;
          best_v <= 1'b0;
          // Target wins over budget so a last-step arrival counts.
          if (hit_tgt)      target_reached <= 1'b1;
          else if (hit_max) timeout        <= 1'b1;
        end
        S_FETCH: begin
          fc     <= fc + 3'd1;
          best_q <= cand_q;
          best_a <= cand_a;
          best_v <= cand_v;
          tgt    <= target_state;
          if (fetch_last) begin
            if (cand_v) move_state <= dest[cand_a];
            else        stuck      <= 1'b1;
          end
        end
        S_MOVE: begin
          if (move_ready) begin
            cur_state  <= move_state;
            step_count <= step_count + STEP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign q_rd_en     = (st == S_FETCH) && !fc[2];
  assign q_rd_action = fc[1:0];
  assign q_rd_state  = cur_state;
  assign move_valid  = (st == S_MOVE);
  assign busy        = (st == S_FETCH) || (st == S_MOVE) || (st == S_CHECK);
  assign done        = (st == S_DONE);

endmodule

// File: tb/tb_q_greedy_stepper.sv
// Directed bench for q_greedy_stepper: default instance plus a
// MAX_STEPS=3 instance for budget boundaries.
module tb_q_greedy_stepper;

  localparam int SW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_a, start_b;
  logic [SW-1:0] start_state, target_state;
  logic [SW-1:0] blocked [16];
  logic          move_ready;

  logic          q_rd_en_a, q_rd_en_b;
  logic [SW-1:0] q_rd_state_a, q_rd_state_b;
  logic [1:0]    q_rd_action_a, q_rd_action_b;
  logic [31:0]   q_rd_data_a, q_rd_data_b;
  logic          move_valid_a, move_valid_b;
  logic [SW-1:0] move_state_a, move_state_b;
  logic [SW-1:0] cur_state_a, cur_state_b;
  logic [6:0]    step_count_a;
  logic [1:0]    step_count_b;
  logic          busy_a, busy_b, done_a, done_b;
  logic          tr_a, tr_b, stuck_a, stuck_b, to_a, to_b;

  logic [31:0] qt [37][4];
  int cyc = 0;
  int rd_cnt_a = 0;
  int rd_cnt_b = 0;
  int c0 = 0;
  int n_chk = 0;
  int n_pass = 0;

  q_greedy_stepper u_dut_a (
    .clk(clk), .rst(rst), .start(start_a),
    .start_state(start_state), .target_state(target_state),
    .blocked(blocked),
    .q_rd_en(q_rd_en_a), .q_rd_state(q_rd_state_a),
    .q_rd_action(q_rd_action_a), .q_rd_data(q_rd_data_a),
    .move_valid(move_valid_a), .move_state(move_state_a),
    .move_ready(move_ready),
    .cur_state(cur_state_a), .step_count(step_count_a),
    .busy(busy_a), .done(done_a),
    .target_reached(tr_a), .stuck(stuck_a), .timeout(to_a)
  );

  q_greedy_stepper #(.MAX_STEPS(3)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b),
    .start_state(start_state), .target_state(target_state),
    .blocked(blocked),
    .q_rd_en(q_rd_en_b), .q_rd_state(q_rd_state_b),
    .q_rd_action(q_rd_action_b), .q_rd_data(q_rd_data_b),
    .move_valid(move_valid_b), .move_state(move_state_b),
    .move_ready(move_ready),
    .cur_state(cur_state_b), .step_count(step_count_b),
    .busy(busy_b), .done(done_b),
    .target_reached(tr_b), .stuck(stuck_b), .timeout(to_b)
  );

  always #5 clk = ~clk;

  // Q-table RAM model: one-cycle read latency.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (q_rd_en_a) begin
      q_rd_data_a <= qt[q_rd_state_a][q_rd_action_a];
      rd_cnt_a    <= rd_cnt_a + 1;
    end
    if (q_rd_en_b) begin
      q_rd_data_b <= qt[q_rd_state_b][q_rd_action_b];
      rd_cnt_b    <= rd_cnt_b + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  task automatic set_row(input int c, input int a0, input int a1,
                         input int a2, input int a3);
    qt[c][0] = a0;
    qt[c][1] = a1;
    qt[c][2] = a2;
    qt[c][3] = a3;
  endtask

  task automatic pulse(input bit b, input int s, input int t);
    @(negedge clk);
    start_state  = SW'(s);
    target_state = SW'(t);
    if (b) start_b = 1'b1;
    else   start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    c0 = cyc;
  endtask

  task automatic wait_done(input bit b, output int n);
    while (!(b ? done_b : done_a) && (cyc - c0) < 300) @(negedge clk);
    n = cyc - c0;
  endtask

  task automatic wait_mv();
    while (!move_valid_a && (cyc - c0) < 50) @(negedge clk);
    chk("mv_seen", move_valid_a, 1);
  endtask

  task automatic rst_pulse();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n, r0;
    bit ok;
    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    start_state = '0;
    target_state = '0;
    move_ready = 1'b1;
    for (int i = 0; i < 16; i++) blocked[i] = '0;
    for (int c = 0; c < 37; c++) set_row(c, 5, 9, 1, -3);
    repeat (3) @(negedge clk);
    chk("rst_cur", cur_state_a, 0);
    chk("rst_step", step_count_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_mv", move_valid_a, 0);
    chk("rst_rden", q_rd_en_a, 0);
    rst = 1'b0;

    // Greedy path 8,9,10,11,12,18,24,30,36: 8 steps of 7 cycles.
    r0 = rd_cnt_a;
    pulse(0, 8, 36);
    wait_mv();
    chk("first_ms", move_state_a, 9);
    wait_done(0, n);
    chk("run_cycles", n, 57);
    chk("run_tr", tr_a, 1);
    chk("run_stuck", stuck_a, 0);
    chk("run_to", to_a, 0);
    chk("run_steps", step_count_a, 8);
    chk("run_cur", cur_state_a, 36);
    chk("run_reads", rd_cnt_a - r0, 32);
    chk("run_busy", busy_a, 0);

    // Re-arm from DONE with start already on target.
    r0 = rd_cnt_a;
    pulse(0, 5, 5);
    wait_done(0, n);
    chk("eq_cycles", n, 1);
    chk("eq_tr", tr_a, 1);
    chk("eq_steps", step_count_a, 0);
    chk("eq_reads", rd_cnt_a - r0, 0);

    blocked[0] = SW'(2);
    blocked[1] = SW'(7);
    r0 = rd_cnt_a;
    pulse(0, 1, 36);
    wait_done(0, n);
    chk("stk_cycles", n, 6);
    chk("stk_flag", stuck_a, 1);
    chk("stk_tr", tr_a, 0);
    chk("stk_steps", step_count_a, 0);
    chk("stk_reads", rd_cnt_a - r0, 4);
    blocked[0] = '0;
    blocked[1] = '0;

    move_ready = 1'b0;
    set_row(6, 2, 100, 0, 0);
    pulse(0, 6, 36);
    wait_mv();
    chk("redge_ms", move_state_a, 12);
    rst_pulse();

    set_row(7, 1, 2, 3, 100);
    pulse(0, 7, 36);
    wait_mv();
    chk("ledge_ms", move_state_a, 1);
    rst_pulse();

    set_row(8, 7, 7, 0, 0);
    pulse(0, 8, 36);
    wait_mv();
    chk("tie_ms", move_state_a, 14);
    rst_pulse();

    set_row(8, -5, -1, -9, -7);
    pulse(0, 8, 36);
    wait_mv();
    chk("neg_ms", move_state_a, 9);
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!move_valid_a || move_state_a != SW'(9) || step_count_a != 0)
        ok = 1'b0;
    end
    chk("hold_stable", ok, 1);
    pulse(0, 20, 36);
    chk("busy_ign_cur", cur_state_a, 8);
    chk("busy_ign_ms", move_state_a, 9);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_mv", move_valid_a, 0);
    chk("abort_ms", move_state_a, 0);
    chk("abort_cur", cur_state_a, 0);
    chk("abort_busy", busy_a, 0);
    chk("abort_rden", q_rd_en_a, 0);
    @(negedge clk);
    rst = 1'b0;
    move_ready = 1'b1;

    // Budget of 3 on a 8<->9 loop.
    set_row(8, 0, 10, 0, 0);
    set_row(9, 0, 0, 0, 10);
    pulse(1, 8, 36);
    wait_done(1, n);
    chk("to_cycles", n, 22);
    chk("to_flag", to_b, 1);
    chk("to_tr", tr_b, 0);
    chk("to_steps", step_count_b, 3);
    chk("to_cur", cur_state_b, 9);

    // Arrival exactly on the last budgeted step.
    set_row(7, 0, 10, 0, 0);
    set_row(9, 0, 10, 0, 0);
    pulse(1, 7, 10);
    wait_done(1, n);
    chk("last_tr", tr_b, 1);
    chk("last_to", to_b, 0);
    chk("last_steps", step_count_b, 3);
    chk("last_cur", cur_state_b, 10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
